// File: rtl/output_channel_scheduler.sv
// Channel-select sequencer for the filter output multiplexer: manual pass-through
// or round-robin scan over enabled channels with a per-channel dwell of i_dwell+1 strobes.
//
// state  | meaning
// IDLE   | no channel selected yet (after reset or with an empty scan mask)
// SETTLE | select just changed; multiplexer output not yet valid
// DWELL  | multiplexer output belongs to the select; counting strobes in scan mode
module output_channel_scheduler #(
    parameter int NUM_FILTERS = 8,
    parameter int DWELL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_mode,
    input  logic [7:0]             i_manual_channel,
    input  logic [NUM_FILTERS-1:0] i_channel_enable,
    input  logic [DWELL_WIDTH-1:0] i_dwell,
    input  logic                   i_sample_strobe,
    output logic [7:0]             o_select_output_channel,
    output logic                   o_channel_valid,
    output logic                   o_frame_start
);

    typedef enum logic [1:0] {IDLE, SETTLE, DWELL} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             sel_q, sel_d;
    logic                   valid_q, valid_d;
    logic                   fs_q, fs_d;
    logic                   mode_q, mode_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;

    logic [7:0] en8;
    logic [7:0] man_clip;
    logic [7:0] lowest_ch;
    logic [7:0] next_ch;
    logic       above_found;
    logic       cur_en;
    logic       any_en;
    logic       adv;

    assign en8    = 8'(i_channel_enable);
    assign any_en = |i_channel_enable;

    // Descending scan so the last hit is the lowest match.
    always_comb begin
        man_clip    = (i_manual_channel >= 8'(NUM_FILTERS)) ? 8'd0 : i_manual_channel;
        lowest_ch   = 8'd0;
        next_ch     = 8'd0;
        above_found = 1'b0;
        cur_en      = 1'b0;
        for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
            if (en8[3'(k)]) begin
                lowest_ch = 8'(k);
                if (8'(k) > sel_q) begin
                    next_ch     = 8'(k);
                    above_found = 1'b1;
                end
            end
            if (8'(k) == sel_q) cur_en = en8[3'(k)];
        end
        if (!above_found) next_ch = lowest_ch;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        fs_d    = 1'b0;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (!i_mode) begin
                    sel_d   = man_clip;
                    mode_d  = 1'b0;
                    state_d = SETTLE;
                end else if (any_en) begin
                    sel_d   = lowest_ch;
                    fs_d    = 1'b1;
                    mode_d  = 1'b1;
                    state_d = SETTLE;
                end else begin
                    sel_d = 8'd0;
                end
            end
            SETTLE: begin
                cnt_d   = '0;
                valid_d = 1'b1;
                state_d = DWELL;
            end
            DWELL: begin
                if (!i_mode) begin
                    if (mode_q || (man_clip != sel_q)) begin
                        sel_d   = man_clip;
                        valid_d = 1'b0;
                        mode_d  = 1'b0;
                        state_d = SETTLE;
                    end
                end else if (!mode_q) begin
                    mode_d  = 1'b1;
                    valid_d = 1'b0;
                    if (any_en) begin
                        sel_d   = lowest_ch;
                        fs_d    = 1'b1;
                        state_d = SETTLE;
                    end else begin
                        sel_d   = 8'd0;
                        state_d = IDLE;
                    end
                end else if (!any_en) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (!cur_en) begin
                    adv = 1'b1;
                end else if (i_sample_strobe) begin
                    // >= also catches i_dwell lowered below the running count.
                    if (cnt_q >= i_dwell) adv = 1'b1;
                    else                  cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (adv) begin
            cnt_d = '0;
            fs_d  = !above_found;
            if (next_ch != sel_q) begin
                sel_d   = next_ch;
                valid_d = 1'b0;
                state_d = SETTLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 8'd0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_select_output_channel = sel_q;
    assign o_channel_valid         = valid_q;
    assign o_frame_start           = fs_q;

endmodule

// File: tb/tb_output_channel_scheduler.sv
// Directed bench for output_channel_scheduler: table of per-edge vectors plus
// hand-written scan and mid-dwell sequences with hand-computed expectations.
module tb_output_channel_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_mode;
    logic [7:0] i_manual_channel;
    logic [7:0] i_channel_enable;
    logic [7:0] i_dwell;
    logic       i_sample_strobe;
    logic [7:0] o_select_output_channel;
    logic       o_channel_valid;
    logic       o_frame_start;

    int checks   = 0;
    int failures = 0;

    output_channel_scheduler #(.NUM_FILTERS(8), .DWELL_WIDTH(8)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .i_mode                  (i_mode),
        .i_manual_channel        (i_manual_channel),
        .i_channel_enable        (i_channel_enable),
        .i_dwell                 (i_dwell),
        .i_sample_strobe         (i_sample_strobe),
        .o_select_output_channel (o_select_output_channel),
        .o_channel_valid         (o_channel_valid),
        .o_frame_start           (o_frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       mode;
        logic [7:0] man;
        logic [7:0] mask;
        logic [7:0] dwell;
        logic       strobe;
        logic [7:0] e_sel;
        logic       e_valid;
        logic       e_fs;
    } vec_t;

    vec_t tbl[17];
    logic [7:0] scan_ch[4];
    logic [7:0] scan_nx[4];

    // Drive one edge worth of inputs, then compare outputs 1 time unit after the edge.
    task automatic step(input string name, input logic r, input logic m, input logic [7:0] man,
                        input logic [7:0] mask, input logic [7:0] dw, input logic stb,
                        input logic [7:0] e_sel, input logic e_v, input logic e_fs);
        rst = r; i_mode = m; i_manual_channel = man;
        i_channel_enable = mask; i_dwell = dw; i_sample_strobe = stb;
        @(posedge clk);
        #1;
        checks++;
        if (o_select_output_channel !== e_sel) begin
            failures++;
            $display("FAIL %s select got=%0d want=%0d", name, o_select_output_channel, e_sel);
        end
        checks++;
        if (o_channel_valid !== e_v) begin
            failures++;
            $display("FAIL %s valid got=%0b want=%0b", name, o_channel_valid, e_v);
        end
        checks++;
        if (o_frame_start !== e_fs) begin
            failures++;
            $display("FAIL %s frame_start got=%0b want=%0b", name, o_frame_start, e_fs);
        end
    endtask

    initial begin
        //            rst  mode man    mask   dwell  stb  sel    v    fs
        tbl[0]  = '{1'b1, 1'b1, 8'd0, 8'hFF, 8'd1, 1'b0, 8'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'd0, 8'hFF, 8'd1, 1'b0, 8'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'd0, 8'hFF, 8'd1, 1'b0, 8'd0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 8'd0, 8'hFF, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'd6, 8'hFF, 8'd1, 1'b0, 8'd6, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'd6, 8'hFF, 8'd1, 1'b0, 8'd6, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'd6, 8'hFF, 8'd1, 1'b1, 8'd6, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'd9, 8'hFF, 8'd1, 1'b0, 8'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'd9, 8'hFF, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'd9, 8'hFF, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'd9, 8'h08, 8'd0, 1'b0, 8'd3, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 8'd9, 8'h08, 8'd0, 1'b0, 8'd3, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'd9, 8'h08, 8'd0, 1'b1, 8'd3, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 8'd9, 8'h08, 8'd0, 1'b0, 8'd3, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 8'd9, 8'h08, 8'd0, 1'b1, 8'd3, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 8'd9, 8'h00, 8'd0, 1'b0, 8'd3, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 8'd9, 8'h00, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0};

        scan_ch[0] = 8'd0; scan_ch[1] = 8'd2; scan_ch[2] = 8'd5; scan_ch[3] = 8'd7;
        scan_nx[0] = 8'd2; scan_nx[1] = 8'd5; scan_nx[2] = 8'd7; scan_nx[3] = 8'd0;

        rst = 1'b1; i_mode = 1'b1; i_manual_channel = 8'd0;
        i_channel_enable = 8'hFF; i_dwell = 8'd1; i_sample_strobe = 1'b0;

        // Reset, manual mode, single channel and empty mask.
        for (int i = 0; i < 17; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].rst, tbl[i].mode, tbl[i].man, tbl[i].mask,
                 tbl[i].dwell, tbl[i].strobe, tbl[i].e_sel, tbl[i].e_valid, tbl[i].e_fs);
        end

        // Scan over 0xA5 with dwell 1, strobe every 4 edges.
        step("scan_rst", 1'b1, 1'b1, 8'd0, 8'hA5, 8'd1, 1'b0, 8'd0, 1'b0, 1'b0);
        step("scan_go",  1'b0, 1'b1, 8'd0, 8'hA5, 8'd1, 1'b0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            for (int j = 1; j <= 7; j++) begin
                if (j < 7)
                    step($sformatf("scan_ch%0d_e%0d", scan_ch[i], j), 1'b0, 1'b1, 8'd0, 8'hA5,
                         8'd1, (j == 3), scan_ch[i], 1'b1, 1'b0);
                else
                    step($sformatf("scan_adv%0d", scan_nx[i]), 1'b0, 1'b1, 8'd0, 8'hA5,
                         8'd1, 1'b1, scan_nx[i], 1'b0, (scan_nx[i] == 8'd0));
            end
        end
        step("scan_end", 1'b0, 1'b1, 8'd0, 8'hA5, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0);

        // Mask loss on the current channel advances without a strobe.
        step("md_rst",   1'b1, 1'b1, 8'd0, 8'hFF, 8'd3, 1'b0, 8'd0, 1'b0, 1'b0);
        step("md_go",    1'b0, 1'b1, 8'd0, 8'hFF, 8'd3, 1'b0, 8'd0, 1'b0, 1'b1);
        step("md_dw0",   1'b0, 1'b1, 8'd0, 8'hFF, 8'd3, 1'b0, 8'd0, 1'b1, 1'b0);
        step("md_lose0", 1'b0, 1'b1, 8'd0, 8'hFE, 8'd3, 1'b0, 8'd1, 1'b0, 1'b0);
        step("md_dw1",   1'b0, 1'b1, 8'd0, 8'hFF, 8'd3, 1'b0, 8'd1, 1'b1, 1'b0);
        step("md_lose1", 1'b0, 1'b1, 8'd0, 8'hFD, 8'd3, 1'b0, 8'd2, 1'b0, 1'b0);
        step("md_dw2",   1'b0, 1'b1, 8'd0, 8'hFF, 8'd3, 1'b0, 8'd2, 1'b1, 1'b0);
        step("md_lose2", 1'b0, 1'b1, 8'd0, 8'hFB, 8'd3, 1'b0, 8'd3, 1'b0, 1'b0);
        step("md_dw3",   1'b0, 1'b1, 8'd0, 8'hFB, 8'd3, 1'b0, 8'd3, 1'b1, 1'b0);
        step("md_lose3", 1'b0, 1'b1, 8'd0, 8'hF7, 8'd3, 1'b0, 8'd4, 1'b0, 1'b0);

        // Reset during SETTLE, then restart.
        step("rs_settle", 1'b1, 1'b1, 8'd0, 8'hF7, 8'd3, 1'b0, 8'd0, 1'b0, 1'b0);
        step("rs_go",     1'b0, 1'b1, 8'd0, 8'hF7, 8'd3, 1'b0, 8'd0, 1'b0, 1'b1);
        step("rs_dw",     1'b0, 1'b1, 8'd0, 8'hF7, 8'd3, 1'b0, 8'd0, 1'b1, 1'b0);

        // Dwell lowered below the count expires on the next strobe.
        step("dl_s1",     1'b0, 1'b1, 8'd0, 8'hF7, 8'd3, 1'b1, 8'd0, 1'b1, 1'b0);
        step("dl_s2",     1'b0, 1'b1, 8'd0, 8'hF7, 8'd3, 1'b1, 8'd0, 1'b1, 1'b0);
        step("dl_lower",  1'b0, 1'b1, 8'd0, 8'hF7, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
        step("dl_expire", 1'b0, 1'b1, 8'd0, 8'hF7, 8'd0, 1'b1, 8'd1, 1'b0, 1'b0);

        // Strobe in SETTLE is lost: channel 1 needs two more strobes.
        step("sl_settle", 1'b0, 1'b1, 8'd0, 8'hF7, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0);
        step("sl_s1",     1'b0, 1'b1, 8'd0, 8'hF7, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0);
        step("sl_s2",     1'b0, 1'b1, 8'd0, 8'hF7, 8'd1, 1'b1, 8'd2, 1'b0, 1'b0);
        step("sl_dw",     1'b0, 1'b1, 8'd0, 8'hF7, 8'd1, 1'b0, 8'd2, 1'b1, 1'b0);

        // Mode change beats a coincident expiring strobe; manual->auto restarts the frame.
        step("mc_manual", 1'b0, 1'b0, 8'd5, 8'hF7, 8'd0, 1'b1, 8'd5, 1'b0, 1'b0);
        step("mc_dw5",    1'b0, 1'b0, 8'd5, 8'hF7, 8'd0, 1'b0, 8'd5, 1'b1, 1'b0);
        step("mc_auto",   1'b0, 1'b1, 8'd5, 8'hF7, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
        step("mc_dw0",    1'b0, 1'b1, 8'd5, 8'hF7, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
